// File: rtl/pcileech_msix_pkg.sv
// rtl/pcileech_msix_pkg.sv - shared TLP codes, FSM states and table-entry type for the MSI-X transmitter
package pcileech_msix_pkg;

  localparam logic [7:0] MWR32 = 8'h40;
  localparam logic [7:0] MWR64 = 8'h60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVAL,
    ST_BEAT0,
    ST_BEAT1
  } msix_tx_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic        vmask;
  } msix_entry_t;

endpackage

// File: rtl/pcileech_msix_tlp_build.sv
// rtl/pcileech_msix_tlp_build.sv - combinational 1-DW MWr TLP formatter for one MSI-X table entry
module pcileech_msix_tlp_build
  import pcileech_msix_pkg::*;
(
  input  msix_entry_t  entry,
  input  logic [15:0]  pcie_id,
  output logic [127:0] beat0,
  output logic [127:0] beat1,
  output logic         is_4dw
);

  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] addr_lo;
  logic        unused_vmask;

  assign unused_vmask = entry.vmask;

  always_comb begin
    is_4dw  = |entry.addr[63:32];
    // TC, attr, TD, EP all zero; length is a single DW
    dw0     = {(is_4dw ? MWR64 : MWR32), 14'h0, 10'd1};
    dw1     = {pcie_id, 8'h00, 4'h0, 4'hF};
    addr_lo = {entry.addr[31:2], 2'b00};
    if (is_4dw) begin
      beat0 = {addr_lo, entry.addr[63:32], dw1, dw0};
      beat1 = {96'h0, entry.data};
    end else begin
      beat0 = {entry.data, addr_lo, dw1, dw0};
      beat1 = '0;
    end
  end

endmodule

// File: rtl/pcileech_tlps128_msix_tx.sv
// rtl/pcileech_tlps128_msix_tx.sv - MSI-X message transmitter: table lookup, mask/PBA rules, MWr on 128-bit AXIS
// Optional MSIX_TX_STATS_EN adds saturating stat_sent/stat_drop counters.
module pcileech_tlps128_msix_tx
  import pcileech_msix_pkg::*;
#(
  parameter  int NUM_VECTORS = 16,
  localparam int VEC_W       = $clog2(NUM_VECTORS)
) (
  input  logic                   clk_pcie,
  input  logic                   rst,
  input  logic [15:0]            pcie_id,
  input  logic                   cfg_msix_en,
  input  logic                   cfg_msix_fmask,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [VEC_W-1:0]       req_vector,
  output logic                   tbl_rd_en,
  output logic [VEC_W-1:0]       tbl_rd_idx,
  input  logic [63:0]            tbl_addr,
  input  logic [31:0]            tbl_data,
  input  logic                   tbl_vmask,
  output logic [NUM_VECTORS-1:0] pba,
  output logic [127:0]           tx_tdata,
  output logic [3:0]             tx_tkeepdw,
  output logic                   tx_tlast,
  output logic                   tx_tvalid,
  input  logic                   tx_tready,
  output logic                   stat_err
`ifdef MSIX_TX_STATS_EN
  ,
  output logic [31:0]            stat_sent,
  output logic [31:0]            stat_drop
`endif
);

  localparam logic [VEC_W-1:0] SCAN_LAST = VEC_W'(NUM_VECTORS - 1);

  msix_tx_state_t         state_q, state_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic                   retry_q, retry_d;
  logic [VEC_W-1:0]       scan_q, scan_d;
  logic [NUM_VECTORS-1:0] pba_q, pba_d;
  logic [127:0]           tdata_q, tdata_d;
  logic [127:0]           beat1_q, beat1_d;
  logic [3:0]             tkeep_q, tkeep_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;
  logic                   err_q, err_d;
  logic                   sent_inc, drop_inc;

  msix_entry_t  entry;
  logic [127:0] bld_beat0, bld_beat1;
  logic         bld_is_4dw;

  assign entry = '{addr: tbl_addr, data: tbl_data, vmask: tbl_vmask};

  pcileech_msix_tlp_build u_build (
    .entry   (entry),
    .pcie_id (pcie_id),
    .beat0   (bld_beat0),
    .beat1   (bld_beat1),
    .is_4dw  (bld_is_4dw)
  );

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign tbl_rd_en  = (state_q == ST_LOOKUP) && !rst;
  assign tbl_rd_idx = vec_q;
  assign pba        = pba_q;
  assign tx_tdata   = tdata_q;
  assign tx_tkeepdw = tkeep_q;
  assign tx_tlast   = tlast_q;
  assign tx_tvalid  = tvalid_q;
  assign stat_err   = err_q;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    retry_d  = retry_q;
    scan_d   = scan_q;
    pba_d    = pba_q;
    tdata_d  = tdata_q;
    beat1_d  = beat1_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    err_d    = err_q;
    sent_inc = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        // fresh requests take priority over re-delivering pending vectors
        if (req_valid) begin
          vec_d   = req_vector;
          retry_d = 1'b0;
          state_d = ST_LOOKUP;
        end else if (pba_q[scan_q]) begin
          vec_d   = scan_q;
          retry_d = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_EVAL;
      ST_EVAL: begin
        state_d = ST_IDLE;
        if (!cfg_msix_en) begin
          drop_inc = 1'b1;
          if (retry_q) pba_d[vec_q] = 1'b0;
        end else if (tbl_addr[1:0] != 2'b00) begin
          drop_inc     = 1'b1;
          err_d        = 1'b1;
          pba_d[vec_q] = 1'b0;
        end else if (cfg_msix_fmask || tbl_vmask) begin
          pba_d[vec_q] = 1'b1;
        end else begin
          pba_d[vec_q] = 1'b0;
          tdata_d      = bld_beat0;
          beat1_d      = bld_beat1;
          tkeep_d      = 4'hF;
          tlast_d      = !bld_is_4dw;
          tvalid_d     = 1'b1;
          state_d      = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (tvalid_q && tx_tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = 4'h0;
            tlast_d  = 1'b0;
            sent_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            tdata_d  = beat1_q;
            tkeep_d  = 4'h1;
            tlast_d  = 1'b1;
            state_d  = ST_BEAT1;
          end
        end
      end
      ST_BEAT1: begin
        if (tvalid_q && tx_tready) begin
          tvalid_d = 1'b0;
          tdata_d  = '0;
          tkeep_d  = 4'h0;
          tlast_d  = 1'b0;
          sent_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      retry_q  <= 1'b0;
      scan_q   <= '0;
      pba_q    <= '0;
      tdata_q  <= '0;
      beat1_q  <= '0;
      tkeep_q  <= 4'h0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      retry_q  <= retry_d;
      scan_q   <= scan_d;
      pba_q    <= pba_d;
      tdata_q  <= tdata_d;
      beat1_q  <= beat1_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      err_q    <= err_d;
    end
  end

`ifdef MSIX_TX_STATS_EN
  logic [31:0] sent_q, drop_q;

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      if (sent_inc && !(&sent_q)) sent_q <= sent_q + 32'd1;
      if (drop_inc && !(&drop_q)) drop_q <= drop_q + 32'd1;
    end
  end

  assign stat_sent = sent_q;
  assign stat_drop = drop_q;
`else
  logic unused_stats;
  assign unused_stats = sent_inc ^ drop_inc;
`endif

endmodule

// File: tb/tb_pcileech_tlps128_msix_tx.sv
// tb/tb_pcileech_tlps128_msix_tx.sv - self-checking bench for the MSI-X transmitter
`timescale 1ns/1ps
module tb_pcileech_tlps128_msix_tx;

  localparam int NV = 16;
  localparam int VW = 4;

  typedef struct packed {
    logic [127:0] b0;
    logic [127:0] b1;
    logic         is4;
  } pkt_t;

  logic          clk_pcie = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   pcie_id = 16'h0108;
  logic          cfg_msix_en = 1'b1;
  logic          cfg_msix_fmask = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [VW-1:0] req_vector = '0;
  logic          tbl_rd_en;
  logic [VW-1:0] tbl_rd_idx;
  logic [63:0]   tbl_addr = '0;
  logic [31:0]   tbl_data = '0;
  logic          tbl_vmask = 1'b0;
  logic [NV-1:0] pba;
  logic [127:0]  tx_tdata;
  logic [3:0]    tx_tkeepdw;
  logic          tx_tlast;
  logic          tx_tvalid;
  logic          tx_tready = 1'b1;
  logic          stat_err;
`ifdef MSIX_TX_STATS_EN
  logic [31:0]   stat_sent;
  logic [31:0]   stat_drop;
`endif

  pcileech_tlps128_msix_tx #(.NUM_VECTORS(NV)) dut (
    .clk_pcie       (clk_pcie),
    .rst            (rst),
    .pcie_id        (pcie_id),
    .cfg_msix_en    (cfg_msix_en),
    .cfg_msix_fmask (cfg_msix_fmask),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vector     (req_vector),
    .tbl_rd_en      (tbl_rd_en),
    .tbl_rd_idx     (tbl_rd_idx),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .tbl_vmask      (tbl_vmask),
    .pba            (pba),
    .tx_tdata       (tx_tdata),
    .tx_tkeepdw     (tx_tkeepdw),
    .tx_tlast       (tx_tlast),
    .tx_tvalid      (tx_tvalid),
    .tx_tready      (tx_tready),
    .stat_err       (stat_err)
`ifdef MSIX_TX_STATS_EN
    ,
    .stat_sent      (stat_sent),
    .stat_drop      (stat_drop)
`endif
  );

  always #4 clk_pcie = ~clk_pcie;

  // MSI-X table contents served one cycle after each read strobe
  logic [63:0] tab_addr [NV];
  logic [31:0] tab_data [NV];
  logic        tab_vmask[NV];

  always @(posedge clk_pcie) begin
    if (tbl_rd_en) begin
      tbl_addr  <= tab_addr[tbl_rd_idx];
      tbl_data  <= tab_data[tbl_rd_idx];
      tbl_vmask <= tab_vmask[tbl_rd_idx];
    end
  end

  int tests = 0;
  int fails = 0;
  bit fixed_rdy = 1'b1;
  bit rand_rdy = 1'b0;

  // reference model state
  logic [NV-1:0] m_pba = '0;
  bit            m_err = 1'b0;
  int            m_sent = 0;
  int            m_drop = 0;
  pkt_t          owed[$];

  // monitor state
  int            recv_cnt = 0;
  int            last_n = 0;
  logic [127:0]  last_b0 = '0;
  logic [127:0]  last_b1 = '0;
  logic [3:0]    last_keep1 = '0;
  bit            pend = 1'b0;
  logic [132:0]  p_beat = '0;
  int            bidx = 0;
  pkt_t          cur;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk_pkt(int v);
    pkt_t p;
    logic [31:0] hi, lo, dw0, dw1;
    hi = tab_addr[v][63:32];
    lo = tab_addr[v][31:0] & ~32'h3;
    dw0 = 32'h0000_0001;
    dw0[31:29] = (hi != 0) ? 3'b011 : 3'b010;
    dw0[28:24] = 5'b00000;
    dw1 = {pcie_id, 8'h00, 4'h0, 4'hF};
    p.is4 = (hi != 0);
    if (p.is4) begin
      p.b0 = {lo, hi, dw1, dw0};
      p.b1 = {96'h0, tab_data[v]};
    end else begin
      p.b0 = {tab_data[v], lo, dw1, dw0};
      p.b1 = '0;
    end
    return p;
  endfunction

  task automatic m_eval(int v, bit retry);
    if (!cfg_msix_en) begin
      m_drop++;
      if (retry) m_pba[v] = 1'b0;
    end else if (tab_addr[v][1:0] != 2'b00) begin
      m_drop++;
      m_err = 1'b1;
      m_pba[v] = 1'b0;
    end else if (cfg_msix_fmask || tab_vmask[v]) begin
      m_pba[v] = 1'b1;
    end else begin
      m_pba[v] = 1'b0;
      owed.push_back(mk_pkt(v));
      m_sent++;
    end
  endtask

  // pending vectors are retried until their outcome no longer changes
  task automatic m_settle();
    for (int v = 0; v < NV; v++) if (m_pba[v]) m_eval(v, 1'b1);
  endtask

  task automatic m_reset();
    m_pba = '0;
    m_err = 1'b0;
    m_sent = 0;
    m_drop = 0;
    owed.delete();
  endtask

  task automatic monitor();
    int idx;
    if (rst) begin
      pend = 1'b0;
      bidx = 0;
      return;
    end
    if (pend) begin
      chk("beat_hold_valid", tx_tvalid, 1'b1);
      chk("beat_hold_data", {tx_tlast, tx_tkeepdw, tx_tdata}, p_beat);
    end
    if (tx_tvalid && tx_tready) begin
      if (bidx == 0) begin
        idx = -1;
        foreach (owed[i]) if (idx < 0 && owed[i].b0 === tx_tdata) idx = i;
        tests++;
        if (idx < 0) begin
          fails++;
          $display("FAIL unexpected_tlp: got beat0 %h, no owed message matches", tx_tdata);
          cur.is4 = !tx_tlast;
          cur.b1 = '0;
        end else begin
          cur = owed[idx];
          owed.delete(idx);
        end
        chk("beat0_keep", tx_tkeepdw, 4'hF);
        chk("beat0_last", tx_tlast, !cur.is4);
        last_b0 = tx_tdata;
        if (tx_tlast) begin
          recv_cnt++;
          last_n = 1;
        end else begin
          bidx = 1;
        end
      end else begin
        chk("beat1_data", tx_tdata, cur.b1);
        chk("beat1_keep", tx_tkeepdw, 4'h1);
        chk("beat1_last", tx_tlast, 1'b1);
        last_b1 = tx_tdata;
        last_keep1 = tx_tkeepdw;
        recv_cnt++;
        last_n = 2;
        bidx = 0;
      end
    end
    pend = tx_tvalid && !tx_tready;
    p_beat = {tx_tlast, tx_tkeepdw, tx_tdata};
  endtask

  task automatic tick();
    @(posedge clk_pcie);
    #1 tx_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    @(negedge clk_pcie);
    monitor();
  endtask

  task automatic do_req(int v);
    int n = 0;
    bit ok = 1'b0;
    req_vector = VW'(v);
    req_valid = 1'b1;
    while (!ok && n < 400) begin
      ok = req_ready;
      tick();
      n++;
    end
    req_valid = 1'b0;
    if (ok) m_eval(v, 1'b0);
    else chk("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_recv(input string name, int target, int budget);
    int n = 0;
    while (recv_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, recv_cnt, target);
  endtask

  task automatic wait_tvalid(input string name);
    int n = 0;
    while (!tx_tvalid && n < 40) begin
      tick();
      n++;
    end
    chk(name, tx_tvalid, 1'b1);
  endtask

  task automatic checkpoint(input string tag);
    repeat (8 * NV + 40) tick();
    chk({tag, "_pba"}, pba, m_pba);
    chk({tag, "_err"}, stat_err, m_err);
    chk({tag, "_owed_left"}, owed.size(), 0);
`ifdef MSIX_TX_STATS_EN
    chk({tag, "_sent"}, stat_sent, m_sent);
    chk({tag, "_drop"}, stat_drop, m_drop);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    m_reset();
    tick();
  endtask

  initial begin
    int base;
    for (int v = 0; v < NV; v++) begin
      tab_addr[v] = 64'hFEE0_0000 + 64'(v * 16);
      tab_data[v] = 32'(v);
      tab_vmask[v] = 1'b0;
    end

    // reset values
    repeat (2) tick();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_tbl_rd_en", tbl_rd_en, 1'b0);
    chk("rst_pba", pba, 16'h0);
    chk("rst_tvalid", tx_tvalid, 1'b0);
    chk("rst_tlast", tx_tlast, 1'b0);
    chk("rst_tdata", tx_tdata, 128'h0);
    chk("rst_tkeep", tx_tkeepdw, 4'h0);
    chk("rst_err", stat_err, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", req_ready, 1'b1);

    // 3DW message and request-to-tvalid latency
    tab_addr[3] = 64'h0000_0000_FEE0_0000;
    tab_data[3] = 32'h0000_4021;
    do_req(3);
    chk("lat_rd_en", tbl_rd_en, 1'b1);
    chk("lat_rd_idx", tbl_rd_idx, 4'd3);
    tick();
    chk("lat_n2_tvalid", tx_tvalid, 1'b0);
    tick();
    chk("lat_n3_tvalid", tx_tvalid, 1'b1);
    wait_recv("t1_recv", 1, 10);
    chk("t1_dw0", last_b0[31:0], 32'h4000_0001);
    chk("t1_dw1", last_b0[63:32], 32'h0108_000F);
    chk("t1_dw2", last_b0[95:64], 32'hFEE0_0000);
    chk("t1_dw3", last_b0[127:96], 32'h0000_4021);
    chk("t1_beats", last_n, 1);

    // 4DW message
    tab_addr[9] = 64'h0000_0001_2345_6780;
    tab_data[9] = 32'hCAFE_0009;
    do_req(9);
    wait_recv("t2_recv", 2, 20);
    chk("t2_dw0", last_b0[31:0], 32'h6000_0001);
    chk("t2_dw2", last_b0[95:64], 32'h0000_0001);
    chk("t2_dw3", last_b0[127:96], 32'h2345_6780);
    chk("t2_b1", last_b1, {96'h0, 32'hCAFE_0009});
    chk("t2_keep1", last_keep1, 4'h1);
    chk("t2_beats", last_n, 2);

    // vector mask: pending, then delivered by the scan once unmasked
    tab_vmask[5] = 1'b1;
    base = recv_cnt;
    do_req(5);
    repeat (4) tick();
    chk("t3_pba", pba, 16'h0020);
    chk("t3_no_tlp", recv_cnt, base);
    tab_vmask[5] = 1'b0;
    m_settle();
    wait_recv("t3_retry_recv", base + 1, NV + 8);
    repeat (2) tick();
    chk("t3_pba_clear", pba, 16'h0000);

    // function mask with a repeated request
    cfg_msix_fmask = 1'b1;
    base = recv_cnt;
    do_req(2);
    do_req(2);
    repeat (4) tick();
    chk("t4_pba", pba, 16'h0004);
    chk("t4_no_tlp", recv_cnt, base);
    cfg_msix_fmask = 1'b0;
    m_settle();
    wait_recv("t4_recv", base + 1, 2 * NV + 8);
    repeat (40) tick();
    chk("t4_exactly_one", recv_cnt, base + 1);
    checkpoint("t4");

    // back-pressure stall on a 4DW beat
    tab_addr[12] = 64'h0000_0002_0000_1000;
    tab_data[12] = 32'h1234_5678;
    fixed_rdy = 1'b0;
    base = recv_cnt;
    do_req(12);
    wait_tvalid("t5_tvalid");
    repeat (10) tick();
    chk("t5_stall_beat0", tx_tdata, {32'h0000_1000, 32'h0000_0002, 32'h0108_000F, 32'h6000_0001});
    fixed_rdy = 1'b1;
    wait_recv("t5_recv", base + 1, 10);
    chk("t5_b1", last_b1, {96'h0, 32'h1234_5678});

    // reset while BEAT1 is outstanding, with a pending masked vector
    tab_vmask[7] = 1'b1;
    do_req(7);
    repeat (4) tick();
    chk("t5_pba7", pba, 16'h0080);
    fixed_rdy = 1'b0;
    do_req(12);
    wait_tvalid("t5b_tvalid");
    fixed_rdy = 1'b1;
    tick();
    fixed_rdy = 1'b0;
    tick();
    chk("t5b_beat1_keep", tx_tkeepdw, 4'h1);
    chk("t5b_beat1_last", tx_tlast, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5b_rst_tvalid", tx_tvalid, 1'b0);
    chk("t5b_rst_pba", pba, 16'h0000);
    rst = 1'b0;
    m_reset();
    fixed_rdy = 1'b1;
    tab_vmask[7] = 1'b0;
    checkpoint("t5b");

    // disabled MSI-X and a misaligned address
    cfg_msix_en = 1'b0;
    do_req(1);
    checkpoint("t6a");
    chk("t6_err_clear", stat_err, 1'b0);
    cfg_msix_en = 1'b1;
    tab_addr[4] = 64'h0000_0000_FEE0_0002;
    do_req(4);
    checkpoint("t6b");
    chk("t6_err_set", stat_err, 1'b1);
`ifdef MSIX_TX_STATS_EN
    chk("t6_drop_lit", stat_drop, 32'd2);
`endif

    // randomized phase
    do_reset();
    for (int v = 0; v < NV; v++) begin
      int kind;
      logic [31:0] lo;
      kind = $urandom_range(0, 9);
      lo = $urandom;
      if (kind == 0) begin
        lo[1:0] = 2'($urandom_range(1, 3));
        tab_addr[v] = {32'h0, lo};
      end else if (kind <= 3) begin
        tab_addr[v] = {($urandom | 32'h1), lo & ~32'h3};
      end else begin
        tab_addr[v] = {32'h0, lo & ~32'h3};
      end
      tab_data[v] = $urandom;
      tab_vmask[v] = ($urandom_range(0, 3) == 0);
    end
    rand_rdy = 1'b1;
    for (int it = 0; it < 50; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 1) begin
        cfg_msix_en = ($urandom_range(0, 3) != 0);
        cfg_msix_fmask = ($urandom_range(0, 2) == 0);
        m_settle();
      end else if (op <= 3) begin
        int v;
        v = $urandom_range(0, NV - 1);
        tab_vmask[v] = !tab_vmask[v];
        m_settle();
      end else begin
        do_req($urandom_range(0, NV - 1));
      end
      checkpoint("rnd");
    end
    cfg_msix_en = 1'b1;
    cfg_msix_fmask = 1'b0;
    for (int v = 0; v < NV; v++) tab_vmask[v] = 1'b0;
    m_settle();
    checkpoint("rnd_final");
    chk("rnd_pba_drained", pba, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
